// File: rtl/tick_timer_pkg.sv
// ----------------------------------------------------------------------------
// tick_timer_pkg : shared state encoding for the tick timer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_timer_edge_det.sv
// ----------------------------------------------------------------------------
// tick_timer_edge_det : registers the timebase and flags its qualifying edges
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_timer_edge_det #(
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= sig;
    end
  end

  // q resets low, so a high input right after reset reads as a rising edge.
  generate
    if (BOTH_EDGES) begin : g_both
      assign pulse = sig ^ q;
    end else begin : g_rise
      assign pulse = sig & ~q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/tick_timer.sv
// ----------------------------------------------------------------------------
// tick_timer : preset down-counter advanced by edges of the divider timebase
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit BOTH_EDGES  = 1'b0,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hzX,
  input  logic [WIDTH-1:0] preset,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expire,
  output logic             tick
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic             expire_n;
  logic             hz_edge;
  logic             unused_hz_q;

  tick_timer_edge_det #(
    .BOTH_EDGES(BOTH_EDGES)
  ) u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (hzX),
    .pulse(hz_edge),
    .q    (unused_hz_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      expire <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      expire <= expire_n;
      tick   <= hz_edge;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    expire_n = 1'b0;
    if (load) begin
      count_n = preset;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, PAUSE: begin
          if (start) begin
            if (count != '0) begin
              state_n = RUN;
            end else begin
              state_n  = DONE;
              expire_n = 1'b1;
            end
          end
        end
        // start while running is a no-op, so pause and edges still apply.
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (hz_edge) begin
            if (count > WIDTH'(1)) begin
              count_n = count - WIDTH'(1);
            end else begin
              expire_n = 1'b1;
              if (AUTO_RELOAD && (preset != '0)) begin
                count_n = preset;
              end else begin
                count_n = '0;
                state_n = DONE;
              end
            end
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ----------------------------------------------------------------------------
// tb_tick_timer : three timer variants (plain, auto-reload, both-edges) vs model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tick_timer;

  logic       clk = 1'b0;
  logic       rst, hzX, load, start, pause;
  logic [7:0] preset;

  logic [7:0] d_count [3];
  logic       d_run   [3];
  logic       d_done  [3];
  logic       d_exp   [3];
  logic       d_tick  [3];

  always #5 clk = ~clk;

  tick_timer #(.WIDTH(8), .BOTH_EDGES(1'b0), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .hzX(hzX), .preset(preset), .load(load), .start(start),
    .pause(pause), .count(d_count[0]), .running(d_run[0]), .done(d_done[0]),
    .expire(d_exp[0]), .tick(d_tick[0]));

  tick_timer #(.WIDTH(8), .BOTH_EDGES(1'b0), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .hzX(hzX), .preset(preset), .load(load), .start(start),
    .pause(pause), .count(d_count[1]), .running(d_run[1]), .done(d_done[1]),
    .expire(d_exp[1]), .tick(d_tick[1]));

  tick_timer #(.WIDTH(8), .BOTH_EDGES(1'b1), .AUTO_RELOAD(1'b0)) dut2 (
    .clk(clk), .rst(rst), .hzX(hzX), .preset(preset), .load(load), .start(start),
    .pause(pause), .count(d_count[2]), .running(d_run[2]), .done(d_done[2]),
    .expire(d_exp[2]), .tick(d_tick[2]));

  int checks = 0;
  int errors = 0;

  // Reference model: one record per variant, advanced once per clk edge.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_st  [3];
  int m_cnt [3];
  bit m_hzq [3];
  bit m_tick[3];
  bit m_exp [3];

  int exp_cnt  [3];
  int tick_cnt [3];
  bit done_seen[3];

  typedef struct {
    bit       load, start, pause, hz;
    bit [7:0] preset;
    bit [7:0] ecount;
    bit       erun, edone, eexp, etick;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit both = (k == 2);
      bit arl  = (k == 1);
      bit e;
      if (rst) begin
        m_st[k] = M_IDLE; m_cnt[k] = 0; m_hzq[k] = 0; m_tick[k] = 0; m_exp[k] = 0;
        continue;
      end
      e = both ? (hzX != m_hzq[k]) : (hzX && !m_hzq[k]);
      m_tick[k] = e;
      m_hzq[k]  = hzX;
      m_exp[k]  = 0;
      if (load) begin
        m_cnt[k] = preset;
        m_st[k]  = M_IDLE;
      end else if (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) begin
        if (start) begin
          if (m_cnt[k] != 0) m_st[k] = M_RUN;
          else begin m_st[k] = M_DONE; m_exp[k] = 1; end
        end
      end else if (m_st[k] == M_RUN) begin
        if (pause) m_st[k] = M_PAUSE;
        else if (e) begin
          if (m_cnt[k] > 1) m_cnt[k] = m_cnt[k] - 1;
          else begin
            m_exp[k] = 1;
            if (arl && preset != 0) m_cnt[k] = preset;
            else begin m_cnt[k] = 0; m_st[k] = M_DONE; end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d count", k), d_count[k], m_cnt[k]);
      chk($sformatf("dut%0d running", k), d_run[k], m_st[k] == M_RUN);
      chk($sformatf("dut%0d done", k), d_done[k], m_st[k] == M_DONE);
      chk($sformatf("dut%0d expire", k), d_exp[k], m_exp[k]);
      chk($sformatf("dut%0d tick", k), d_tick[k], m_tick[k]);
      exp_cnt[k]  += int'(d_exp[k]);
      tick_cnt[k] += int'(d_tick[k]);
      if (d_done[k]) done_seen[k] = 1;
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = 0; tick_cnt[k] = 0; done_seen[k] = 0;
    end
  endtask

  task automatic run_hz(input int periods, input int half);
    for (int p = 0; p < periods; p++) begin
      hzX = 1'b1;
      for (int i = 0; i < half; i++) cycle();
      hzX = 1'b0;
      for (int i = 0; i < half; i++) cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1; load = 0; start = 0; pause = 0; hzX = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic load_start(input int p);
    preset = 8'(p); load = 1; cycle(); load = 0;
    start = 1; cycle(); start = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_hzq[k] = 0; m_tick[k] = 0; m_exp[k] = 0;
    end
    clear_stats();
    preset = 0;
    do_reset();
    chk("reset count", d_count[0], 0);
    chk("reset running", d_run[0], 0);
    chk("reset done", d_done[0], 0);

    // Directed vectors for the plain variant, starting from reset.
    vecs[0]  = '{1,0,0,0,8'd2, 8'd2,0,0,0,0};
    vecs[1]  = '{0,1,0,1,8'd2, 8'd2,1,0,0,1};
    vecs[2]  = '{0,0,0,1,8'd2, 8'd2,1,0,0,0};
    vecs[3]  = '{0,0,0,0,8'd2, 8'd2,1,0,0,0};
    vecs[4]  = '{0,0,0,1,8'd2, 8'd1,1,0,0,1};
    vecs[5]  = '{0,0,1,1,8'd2, 8'd1,0,0,0,0};
    vecs[6]  = '{0,0,0,0,8'd2, 8'd1,0,0,0,0};
    vecs[7]  = '{0,0,0,1,8'd2, 8'd1,0,0,0,1};
    vecs[8]  = '{0,1,0,0,8'd2, 8'd1,1,0,0,0};
    vecs[9]  = '{1,0,0,1,8'd7, 8'd7,0,0,0,1};
    vecs[10] = '{0,1,0,0,8'd7, 8'd7,1,0,0,0};
    vecs[11] = '{0,0,0,1,8'd7, 8'd6,1,0,0,1};
    vecs[12] = '{0,1,1,0,8'd7, 8'd6,0,0,0,0};
    vecs[13] = '{1,0,0,0,8'd0, 8'd0,0,0,0,0};
    vecs[14] = '{0,1,0,0,8'd0, 8'd0,0,1,1,0};
    vecs[15] = '{0,1,0,1,8'd0, 8'd0,0,1,0,1};
    for (int i = 0; i < 16; i++) begin
      load = vecs[i].load; start = vecs[i].start; pause = vecs[i].pause;
      hzX = vecs[i].hz; preset = vecs[i].preset;
      cycle();
      chk($sformatf("vec%0d count", i), d_count[0], vecs[i].ecount);
      chk($sformatf("vec%0d running", i), d_run[0], vecs[i].erun);
      chk($sformatf("vec%0d done", i), d_done[0], vecs[i].edone);
      chk($sformatf("vec%0d expire", i), d_exp[0], vecs[i].eexp);
      chk($sformatf("vec%0d tick", i), d_tick[0], vecs[i].etick);
    end
    load = 0; start = 0; pause = 0;

    // Countdown 3 -> 0 over four timebase periods of 8 clk.
    do_reset();
    load_start(3);
    clear_stats();
    run_hz(4, 4);
    chk("cd3 count", d_count[0], 0);
    chk("cd3 done", d_done[0], 1);
    chk("cd3 running", d_run[0], 0);
    chk("cd3 expires", exp_cnt[0], 1);
    chk("cd3 ar count", d_count[1], 2);
    chk("cd3 ar expires", exp_cnt[1], 1);
    chk("cd3 be expires", exp_cnt[2], 1);

    // Pause held across three periods, then resume.
    do_reset();
    load_start(8);
    run_hz(3, 4);
    chk("pause pre count", d_count[0], 5);
    clear_stats();
    pause = 1;
    run_hz(3, 4);
    pause = 0;
    chk("pause held count", d_count[0], 5);
    chk("pause ticks", tick_cnt[0], 3);
    chk("pause running", d_run[0], 0);
    start = 1; cycle(); start = 0;
    run_hz(1, 4);
    chk("resume count", d_count[0], 4);

    // Auto-reload cycles 2,1,2,1 without ever reaching done.
    do_reset();
    load_start(2);
    clear_stats();
    run_hz(6, 4);
    chk("ar count", d_count[1], 2);
    chk("ar expires", exp_cnt[1], 3);
    chk("ar done seen", done_seen[1], 0);

    // Both edges: preset 6 expires after three periods.
    do_reset();
    load_start(6);
    clear_stats();
    run_hz(3, 4);
    chk("be count", d_count[2], 0);
    chk("be done", d_done[2], 1);
    chk("be expires", exp_cnt[2], 1);

    // Reset mid-run, then load coinciding with an edge.
    do_reset();
    load_start(9);
    run_hz(2, 4);
    rst = 1; hzX = 1; cycle(); rst = 0; hzX = 0;
    chk("rst count", d_count[0], 0);
    chk("rst running", d_run[0], 0);
    chk("rst done", d_done[0], 0);
    chk("rst expire", d_exp[0], 0);
    chk("rst tick", d_tick[0], 0);
    load_start(4);
    preset = 8'd4; load = 1; hzX = 1; cycle(); load = 0;
    chk("load+edge count", d_count[0], 4);
    chk("load+edge tick", d_tick[0], 1);
    chk("load+edge running", d_run[0], 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) hzX = ~hzX;
      preset = 8'($urandom_range(0, 5));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
